// File: rtl/func_root_unit.sv
// Floor square root of a_bi and floor cube root of b_bi, computed concurrently by
// MSB-first digit-recurrence units; mode_i selects sum, sqrt only or cbrt only.
module func_root_unit #(
  parameter int W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [W-1:0]   a_bi,
  input  logic [W-1:0]   b_bi,
  input  logic [1:0]     mode_i,
  input  logic           start_i,
  output logic [1:0]     busy_o,
  output logic [W/2:0]   y_bo,
  output logic           done_o,
  output logic           error_o
);

  localparam int YW   = W / 2 + 1;
  localparam int NS   = W / 2;
  localparam int NC   = (W + 2) / 3;
  localparam int CB   = 3 * NC;
  localparam int RW   = W + 2;
  localparam int CW   = 3 * NC + 2;
  localparam int MAXI = (NS > NC) ? NS : NC;
  localparam int CNTW = $clog2(MAXI + 1);

  localparam logic [CNTW-1:0] NS_C = CNTW'(NS);
  localparam logic [CNTW-1:0] NC_C = CNTW'(NC);
  localparam logic [CNTW-1:0] MX_C = CNTW'(MAXI);

  if ((W < 4) || (W % 2 != 0)) begin : g_bad_w
    $error("func_root_unit: W must be even and at least 4");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [1:0]       busy_q;
  logic [W-1:0]     a_q;
  logic [CB-1:0]    b_q;
  logic [RW-1:0]    srem_q;
  logic [NS-1:0]    sroot_q;
  logic [CW-1:0]    crem_q;
  logic [NC-1:0]    croot_q;
  logic [CNTW-1:0]  cnt_q;
  logic [YW-1:0]    y_q;
  logic             done_q;
  logic             err_pend_q;
  logic             err_q;

  logic [RW-1:0]    s_rem_sh, s_trial, srem_d;
  logic [NS-1:0]    sroot_d;
  logic [CW-1:0]    c_rem_sh, c_y2w, c_prod, c_trial, crem_d;
  logic [NC-1:0]    croot_d;
  logic             s_ge, c_ge, s_en, c_en;
  logic [CNTW-1:0]  last_c;
  logic [YW-1:0]    y_sum;

  // Square root: bring down two operand bits, try subtracting 4*root+1.
  always_comb begin
    s_rem_sh = RW'({srem_q, a_q[W-1:W-2]});
    s_trial  = RW'({sroot_q, 2'b01});
    s_ge     = (s_rem_sh >= s_trial);
    srem_d   = s_ge ? (s_rem_sh - s_trial) : s_rem_sh;
    sroot_d  = {sroot_q[NS-2:0], s_ge};
  end

  // Cube root: bring down three bits, try subtracting 3*y2*(y2+1)+1 with y2 = 2*root.
  always_comb begin
    c_rem_sh = CW'({crem_q, b_q[CB-1:CB-3]});
    c_y2w    = CW'({croot_q, 1'b0});
    c_prod   = c_y2w * (c_y2w + CW'(1));
    c_trial  = (c_prod << 1) + c_prod + CW'(1);
    c_ge     = (c_rem_sh >= c_trial);
    crem_d   = c_ge ? (c_rem_sh - c_trial) : c_rem_sh;
    croot_d  = {croot_q[NC-2:0], c_ge};
  end

  always_comb begin
    s_en  = busy_q[0] && (cnt_q < NS_C);
    c_en  = busy_q[1] && (cnt_q < NC_C);
    y_sum = YW'(sroot_q) + YW'(croot_q);
    case (busy_q)
      2'b01:   last_c = NS_C;
      2'b10:   last_c = NC_C;
      default: last_c = MX_C;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      busy_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      srem_q     <= '0;
      sroot_q    <= '0;
      crem_q     <= '0;
      croot_q    <= '0;
      cnt_q      <= '0;
      y_q        <= '0;
      done_q     <= 1'b0;
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_pend_q <= 1'b0;
      err_q      <= err_pend_q;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (mode_i == 2'b11) begin
              err_pend_q <= 1'b1;
            end else begin
              a_q     <= a_bi;
              b_q     <= CB'(b_bi);
              srem_q  <= '0;
              sroot_q <= '0;
              crem_q  <= '0;
              croot_q <= '0;
              cnt_q   <= '0;
              busy_q  <= {mode_i != 2'b01, mode_i != 2'b10};
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q + CNTW'(1);
          if (s_en) begin
            srem_q  <= srem_d;
            sroot_q <= sroot_d;
            a_q     <= {a_q[W-3:0], 2'b00};
          end
          if (c_en) begin
            crem_q  <= crem_d;
            croot_q <= croot_d;
            b_q     <= {b_q[CB-4:0], 3'b000};
          end
          // Both engaged units have retired all bits by the time cnt reaches last_c.
          if (cnt_q == last_c) begin
            y_q     <= y_sum;
            done_q  <= 1'b1;
            busy_q  <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign y_bo    = y_q;
  assign done_o  = done_q;
  assign error_o = err_q;

endmodule

// File: doc/func_root_unit.md
FUNC_ROOT_UNIT -- requirements
Module: func_root_unit

Interface
REQ-001 Parameter W, default 8, operand width in bits; the block SHALL accept only even values of W that are at least 4.
REQ-002 Derived constants SHALL be YW = W/2+1 (result width), NS = W/2 (square-root iterations) and NC = ceil(W/3) (cube-root iterations).
REQ-003 clk_i  in  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst_i  in  1  reset, asynchronous and active-low; 0 SHALL clear all state immediately, independent of clk_i.
REQ-005 a_bi  in  W  square-root operand, unsigned.
REQ-006 b_bi  in  W  cube-root operand, unsigned.
REQ-007 mode_i  in  2  operation select, sampled with start_i.
REQ-008 start_i  in  1  request, sampled at a clock edge.
REQ-009 busy_o  out  2  bit0 SHALL mean the square-root unit is engaged in the current operation; bit1 SHALL mean the cube-root unit is engaged.
REQ-010 y_bo  out  YW  result register, unsigned.
REQ-011 done_o  out  1  one-cycle pulse marking that y_bo has been updated.
REQ-012 error_o  out  1  one-cycle pulse marking a rejected mode.

Function
REQ-013 Modes SHALL be: 00 y = isqrt(a) + icbrt(b); 01 y = isqrt(a); 10 y = icbrt(b); 11 reserved.
REQ-014 isqrt and icbrt SHALL be floor roots, with the sum zero-extended to YW bits (no overflow is possible).
REQ-015 The FSM SHALL have states IDLE and RUN; start_i SHALL be accepted only in IDLE.
REQ-016 At an edge k in IDLE with start_i=1 and a valid mode, the block SHALL:
  - capture a_bi, b_bi and mode_i;
  - set the busy_o bit of each engaged unit;
  - enter RUN.
REQ-017 The square-root unit SHALL retire one result bit per cycle, MSB first (shift-subtract), over edges k+1..k+NS.
REQ-018 The cube-root unit SHALL retire one result bit per cycle, MSB first, over edges k+1..k+NC.
REQ-019 The two units SHALL run concurrently.
REQ-020 Latency SHALL be L = (max iterations over engaged units) + 1, giving mode 00: max(NS,NC)+1; mode 01: NS+1; mode 10: NC+1.
REQ-021 At edge k+L the block SHALL:
  - load y_bo;
  - assert done_o for exactly one cycle;
  - clear all busy_o bits;
  - return to IDLE.
REQ-022 busy_o bits SHALL stay constant from edge k to edge k+L.
REQ-023 A disengaged unit's busy_o bit SHALL remain 0 for the whole operation.
REQ-024 start_i while in RUN SHALL be ignored: no capture, no error_o, and in-flight results unaffected.
REQ-025 Operand or mode input changes after edge k SHALL NOT affect the result.
REQ-026 start_i=1 in the cycle done_o is high SHALL be accepted, since the state is IDLE, enabling back-to-back operations with no gap cycle.
REQ-027 Mode 11 with start_i in IDLE SHALL:
  - pulse error_o for one cycle at edge k+1;
  - leave busy_o at 0;
  - leave y_bo unchanged;
  - keep the state at IDLE.
REQ-028 y_bo SHALL hold its last result until the next done_o.
REQ-029 Operands of 0 SHALL yield 0; an all-ones operand SHALL yield the exact floor root.

Reset
REQ-030 While rst_i=0 the block SHALL hold state IDLE, busy_o=00, y_bo=0, done_o=0, error_o=0 and all internal iteration registers at 0.
REQ-031 rst_i asserted mid-operation SHALL abort the operation with no done_o pulse and y_bo=0.
REQ-032 After rst_i deasserts, the first start_i SHALL be accepted at the next edge.

Verification
REQ-033 W=8, mode 00, a=45, b=64 -> busy_o=11 for 5 cycles, then y_bo=10 with a single done_o pulse.
REQ-034 W=8, mode 00, a=255, b=255 -> y_bo=21; the same run with a=0, b=0 -> y_bo=0 and done_o at latency 5.
REQ-035 W=8, mode 01, a=255 -> busy_o=01, y_bo=15 at latency 5; W=8, mode 10, b=255 -> busy_o=10, y_bo=6 at latency 4.
REQ-036 W=16, mode 00, a=65535, b=65535 -> y_bo=295 at latency 9; a=1, b=1 -> y_bo=2.
REQ-037 W=8, mode 11 -> error_o pulse, busy_o=00 and y_bo unchanged; start_i pulsed during RUN -> result of the first operation only.
REQ-038 W=8, rst_i=0 at cycle 2 of RUN -> all outputs 0 and no done_o; the next start with a=12, b=60 (mode 00) -> y_bo=6.
